fetch_grant_scheduler: RTL and testbench
========================================

# fetch_grant_scheduler

Dual-slot warp fetch scheduler that drives the two one-hot grant vectors (GRT_raw_1_RR_IF, GRT_raw_2_RR_IF) into the Fetch stage. Each cycle it selects up to two distinct eligible warps out of 8, in round-robin order. Eligibility depends on warp activity, pending flushes and a per-warp instruction-buffer credit. Credits cover fetches still in flight through the 2-stage fetch pipeline, so an I-Buffer entry can never be overrun.

## Interface

Parameters:
- NUM_WARPS, 8: number of warps. Fixed at 8; other values are unsupported.
- IB_DEPTH, 2: I-Buffer entries per warp. This is the initial and maximum credit. Legal range 1..7.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- Warp_Active  in  8  warp i may be fetched (set by the warp table / SIMT)
- Fetch_Stall  in  1  global fetch hold; no grants while high
- Flush  in  8  per-warp flush, equal to the OR of UpdatePC_Qual1/2/3 for warp i
- IB_Pop  in  8  pulse: one entry of warp i's I-Buffer is consumed this cycle (at most one per warp per cycle)
- GRT_raw_1_RR_IF  out  8  one-hot or zero; fetch slot 0 (decode path ID0)
- GRT_raw_2_RR_IF  out  8  one-hot or zero; fetch slot 1 (decode path ID1); never the same warp as slot 0
- Credit_Err  out  1  sticky; set when IB_Pop hits a full credit counter

## Operation

- State: 3-bit round-robin pointer `ptr`; per-warp credit counter `cred[i]` of width clog2(IB_DEPTH+1); sticky `Credit_Err`.
- Eligibility: elig[i] = Warp_Active[i] & ~Flush[i] & (cred[i] != 0) & ~Fetch_Stall.
- A warp with Flush set gets no grant that cycle. Fetch would kill the resulting Valid_2 anyway.
- Slot 0: the first eligible warp scanning ptr, ptr+1, ..., ptr+7 (mod 8).
- Slot 1: the next eligible warp after slot 0's index in the same wrap-around order, excluding slot 0's warp.
- With fewer than two eligible warps, the unused slot(s) output 8'h00.
- Grants are combinational from the registered state plus the current inputs. They are valid in the same cycle.
- Pointer update:
  - if slot 1 granted: ptr <= idx(slot1)+1 mod 8;
  - else if slot 0 granted: ptr <= idx(slot0)+1 mod 8;
  - else ptr unchanged.
- Credit update per warp i, evaluated in this priority order:
  - Flush[i]: cred <= IB_DEPTH. The flush discards all of warp i's in-flight fetches and its I-Buffer contents; IB_Pop and grant are ignored.
  - Otherwise cred <= cred - granted[i] + IB_Pop[i]. Here granted[i] is the OR of both slots' bit i, which is at most 1.
  - Grant and pop in the same cycle leave cred unchanged.
  - Pop with cred == IB_DEPTH and no grant: cred stays at IB_DEPTH (saturates) and Credit_Err <= 1.
  - Underflow cannot occur, because a grant requires cred != 0.
- Credit_Err clears only on reset.

## Timing

- Reset (rst_n low at a clk edge): ptr = 0, cred[i] = IB_DEPTH for all i, Credit_Err = 0.
- While rst_n is low, both grant outputs are forced to 8'h00.
- Grant-to-fetch latency is 0: a grant in cycle t selects that warp's PC in cycle t. Fetch then produces Valid_2 at t+1 and Valid_3 (instruction to ID) at t+2.
- A credit consumed at edge t+1 is returned only by IB_Pop or Flush. A flush arriving at t+1 or t+2 restores the full credit; the killed fetch is never counted.
- Fetch_Stall high: outputs 8'h00, ptr frozen. Credits still update from IB_Pop and Flush.
- Reset mid-operation: all state is reinitialised at the next edge, regardless of any in-flight grants.

## Test plan

- After reset, all warps active, IB_DEPTH=2, no pops:
  - cycle 0: grants 8'h01 / 8'h02;
  - cycle 1: 8'h04 / 8'h08;
  - cycle 2: 8'h10 / 8'h20;
  - cycle 3: 8'h40 / 8'h80;
  - cycle 4: 8'h01 / 8'h02;
  - from cycle 8 onward: 8'h00 / 8'h00, since every cred is 0.
- Only warp 5 active, ptr = 0:
  - grant slot0 = 8'h20, slot1 = 8'h00 for 2 cycles, then 8'h00;
  - pulsing IB_Pop[5] for one cycle yields exactly one more slot0 grant of 8'h20.
- Warps 3 and 6 active, ptr = 7:
  - slot0 = 8'h08, slot1 = 8'h40, next ptr = 7;
  - the wrap-around scan works from any ptr.
- Flush[2] asserted while warp 2 has cred = 0 and Active[2] = 1:
  - no grant for warp 2 that cycle;
  - next cycle cred[2] = 2 and warp 2 is eligible.
  - Same cycle with IB_Pop[2] = 1: cred[2] is still 2.
- IB_Pop[4] with cred[4] = 2 and no grant: Credit_Err rises next cycle and stays 1; cred[4] stays 2.
- Fetch_Stall high for 3 cycles with all warps eligible:
  - both grants 8'h00 and ptr unchanged;
  - on deassert, grants resume from the held ptr.

Source files
------------

// File: rtl/fetch_grant_scheduler.sv
// fetch_grant_scheduler: dual-slot round-robin warp fetch grants gated by per-warp I-Buffer credits
module fetch_grant_scheduler #(
  parameter int NUM_WARPS = 8,
  parameter int IB_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WARPS-1:0] Warp_Active,
  input  logic                 Fetch_Stall,
  input  logic [NUM_WARPS-1:0] Flush,
  input  logic [NUM_WARPS-1:0] IB_Pop,
  output logic [NUM_WARPS-1:0] GRT_raw_1_RR_IF,
  output logic [NUM_WARPS-1:0] GRT_raw_2_RR_IF,
  output logic                 Credit_Err
);
  localparam int CW = $clog2(IB_DEPTH + 1);
  localparam int PW = $clog2(NUM_WARPS);
  localparam logic [CW-1:0] FULL = CW'(IB_DEPTH);
  logic [PW-1:0] ptr_q, ptr_d, idx, i0, i1;
  logic f0, f1, err_q, err_d;
  logic [CW-1:0] cred_q [NUM_WARPS];
  logic [CW-1:0] cred_d [NUM_WARPS];
  logic [NUM_WARPS-1:0] elig, full, g0, g1, gnt;
  // A warp can be fetched only if active, not being flushed, holding a credit, and fetch is not stalled
  always_comb
    for (int i = 0; i < NUM_WARPS; i++) begin
      full[i] = cred_q[i] == FULL;
      elig[i] = Warp_Active[i] & ~Flush[i] & (cred_q[i] != '0) & ~Fetch_Stall;
    end
  // Scan from ptr: first eligible warp is slot 0, the next one after it is slot 1
  always_comb begin
    f0 = 1'b0;
    f1 = 1'b0;
    i0 = '0;
    i1 = '0;
    idx = '0;
    for (int k = 0; k < NUM_WARPS; k++) begin
      idx = ptr_q + PW'(k);
      if (elig[idx] && !f0) begin
        f0 = 1'b1;
        i0 = idx;
      end else if (elig[idx] && !f1) begin
        f1 = 1'b1;
        i1 = idx;
      end
    end
    g0 = f0 ? NUM_WARPS'(1) << i0 : '0;
    g1 = f1 ? NUM_WARPS'(1) << i1 : '0;
    gnt = g0 | g1;
    ptr_d = f1 ? i1 + PW'(1) : f0 ? i0 + PW'(1) : ptr_q;
  end
  assign GRT_raw_1_RR_IF = rst_n ? g0 : '0;
  assign GRT_raw_2_RR_IF = rst_n ? g1 : '0;
  assign Credit_Err = err_q;
  // Flush refills a warp's credit; otherwise grants consume and pops return one, saturating at full
  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++)
      cred_d[i] = Flush[i] ? FULL :
                  (gnt[i] && !IB_Pop[i]) ? cred_q[i] - CW'(1) :
                  (IB_Pop[i] && !gnt[i] && !full[i]) ? cred_q[i] + CW'(1) : cred_q[i];
    err_d = err_q | (|(IB_Pop & ~Flush & ~gnt & full));
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk)
    if (!rst_n) begin
      ptr_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NUM_WARPS; i++) cred_q[i] <= FULL;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
      for (int i = 0; i < NUM_WARPS; i++) cred_q[i] <= cred_d[i];
    end
endmodule

// File: tb/tb_fetch_grant_scheduler.sv
// tb_fetch_grant_scheduler: directed self-checking bench for fetch_grant_scheduler
module tb_fetch_grant_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] act = '0, flush = '0, pop = '0;
  logic stall = 1'b0;
  logic [7:0] gr1, gr2;
  logic err;
  int n_cmp = 0;
  int n_bad = 0;

  fetch_grant_scheduler #(.NUM_WARPS(8), .IB_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .Warp_Active(act), .Fetch_Stall(stall), .Flush(flush),
    .IB_Pop(pop), .GRT_raw_1_RR_IF(gr1), .GRT_raw_2_RR_IF(gr2), .Credit_Err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    act = '0;
    flush = '0;
    pop = '0;
    stall = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    act = 8'hFF;
    @(negedge clk);
    n_cmp++;
    if (gr1 !== 8'h00) begin n_bad++; $display("FAIL reset_gr1 got %h want 00", gr1); end
    n_cmp++;
    if (gr2 !== 8'h00) begin n_bad++; $display("FAIL reset_gr2 got %h want 00", gr2); end
    step();
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    act = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [7:0] e1 [10] = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h01, 8'h04, 8'h10, 8'h40, 8'h00, 8'h00};
    logic [7:0] e2 [10] = '{8'h02, 8'h08, 8'h20, 8'h80, 8'h02, 8'h08, 8'h20, 8'h80, 8'h00, 8'h00};
    act = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (gr1 !== e1[c]) begin n_bad++; $display("FAIL rr_gr1 cyc %0d got %h want %h", c, gr1, e1[c]); end
      n_cmp++;
      if (gr2 !== e2[c]) begin n_bad++; $display("FAIL rr_gr2 cyc %0d got %h want %h", c, gr2, e2[c]); end
      step();
    end
  endtask

  task automatic test_single_warp();
    logic [7:0] e1 [6] = '{8'h20, 8'h20, 8'h00, 8'h00, 8'h20, 8'h00};
    do_reset();
    act = 8'h20;
    for (int c = 0; c < 6; c++) begin
      pop = (c == 3) ? 8'h20 : 8'h00;
      @(negedge clk);
      n_cmp++;
      if (gr1 !== e1[c]) begin n_bad++; $display("FAIL single_gr1 cyc %0d got %h want %h", c, gr1, e1[c]); end
      n_cmp++;
      if (gr2 !== 8'h00) begin n_bad++; $display("FAIL single_gr2 cyc %0d got %h want 00", c, gr2); end
      step();
    end
    pop = '0;
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL single_err got %b want 0", err); end
  endtask

  task automatic test_wrap();
    logic [7:0] a [3] = '{8'h40, 8'h48, 8'hFF};
    logic [7:0] e1 [3] = '{8'h40, 8'h08, 8'h80};
    logic [7:0] e2 [3] = '{8'h00, 8'h40, 8'h01};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      act = a[c];
      @(negedge clk);
      n_cmp++;
      if (gr1 !== e1[c]) begin n_bad++; $display("FAIL wrap_gr1 cyc %0d got %h want %h", c, gr1, e1[c]); end
      n_cmp++;
      if (gr2 !== e2[c]) begin n_bad++; $display("FAIL wrap_gr2 cyc %0d got %h want %h", c, gr2, e2[c]); end
      step();
    end
  endtask

  task automatic test_flush();
    logic [7:0] e1 [6] = '{8'h04, 8'h04, 8'h00, 8'h04, 8'h04, 8'h00};
    do_reset();
    act = 8'hFF;
    flush = 8'h01;
    @(negedge clk);
    n_cmp++;
    if (gr1 !== 8'h02) begin n_bad++; $display("FAIL flush_block_gr1 got %h want 02", gr1); end
    n_cmp++;
    if (gr2 !== 8'h04) begin n_bad++; $display("FAIL flush_block_gr2 got %h want 04", gr2); end
    do_reset();
    act = 8'h04;
    for (int c = 0; c < 6; c++) begin
      flush = (c == 2) ? 8'h04 : 8'h00;
      pop = (c == 2) ? 8'h04 : 8'h00;
      @(negedge clk);
      n_cmp++;
      if (gr1 !== e1[c]) begin n_bad++; $display("FAIL flush_gr1 cyc %0d got %h want %h", c, gr1, e1[c]); end
      step();
    end
    flush = '0;
    pop = '0;
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL flush_err got %b want 0", err); end
  endtask

  task automatic test_credit_err();
    logic [7:0] e1 [4] = '{8'h00, 8'h10, 8'h10, 8'h00};
    do_reset();
    pop = 8'h10;
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL cerr_before got %b want 0", err); end
    step();
    pop = '0;
    for (int c = 0; c < 4; c++) begin
      act = (c == 0) ? 8'h00 : 8'h10;
      @(negedge clk);
      n_cmp++;
      if (err !== 1'b1) begin n_bad++; $display("FAIL cerr_sticky cyc %0d got %b want 1", c, err); end
      n_cmp++;
      if (gr1 !== e1[c]) begin n_bad++; $display("FAIL cerr_gr1 cyc %0d got %h want %h", c, gr1, e1[c]); end
      step();
    end
    do_reset();
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL cerr_clear got %b want 0", err); end
  endtask

  task automatic test_stall();
    logic [7:0] e1 [5] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h04};
    logic [7:0] e2 [5] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h08};
    do_reset();
    act = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      stall = (c >= 1 && c <= 3);
      @(negedge clk);
      n_cmp++;
      if (gr1 !== e1[c]) begin n_bad++; $display("FAIL stall_gr1 cyc %0d got %h want %h", c, gr1, e1[c]); end
      n_cmp++;
      if (gr2 !== e2[c]) begin n_bad++; $display("FAIL stall_gr2 cyc %0d got %h want %h", c, gr2, e2[c]); end
      step();
    end
  endtask

  task automatic test_mid_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (gr1 !== 8'h00) begin n_bad++; $display("FAIL midrst_gr1 got %h want 00", gr1); end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (gr1 !== 8'h01) begin n_bad++; $display("FAIL midrst_after_gr1 got %h want 01", gr1); end
    n_cmp++;
    if (gr2 !== 8'h02) begin n_bad++; $display("FAIL midrst_after_gr2 got %h want 02", gr2); end
    step();
  endtask

  initial begin
    step();
    test_reset();
    test_round_robin();
    test_single_warp();
    test_wrap();
    test_flush();
    test_credit_err();
    test_stall();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
